// File: rtl/user_proj_timer_pkg.sv
// user_proj_timer_pkg: register map, CTRL bit indices, parameter limits and byte-lane merge shared by the timer array.
package user_proj_timer_pkg;

    localparam int N_CH_MIN  = 1;
    localparam int N_CH_MAX  = 8;
    localparam int CNT_W_MIN = 8;
    localparam int CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam logic [7:0] ADR_IRQ_PEND = 8'h80;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_OE  = 3;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/user_proj_timer_ch.sv
// user_proj_timer_ch: one down-counting timer channel (CTRL/LOAD/COUNT/STATUS) with a toggle output.
module user_proj_timer_ch
    import user_proj_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             halt_i,
    input  logic             wr_ctrl_i,
    input  logic             wr_load_i,
    input  logic             wr_status_i,
    input  logic [31:0]      wdat_i,
    input  logic [3:0]       sel_i,
    output logic [3:0]       ctrl_o,
    output logic [CNT_W-1:0] load_o,
    output logic [CNT_W-1:0] count_o,
    output logic             exp_o,
    output logic             io_o
);

    logic [3:0]       ctrl_q, ctrl_d, ctrl_wr;
    logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
    logic [31:0]      load_m;
    logic             exp_q, exp_d, io_q, io_d, start_q, start_d, run, expire;

    // start_q marks the cycle after EN rises; that edge loads COUNT instead of counting
    always_comb begin
        load_m  = merge_be(32'(load_q), wdat_i, sel_i);
        ctrl_wr = sel_i[0] ? wdat_i[3:0] : ctrl_q;
        run     = ctrl_q[CTRL_EN] & ~start_q & ~halt_i;
        expire  = run & (count_q == '0);
        ctrl_d  = ctrl_q;
        ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN] & ~(expire & ~ctrl_q[CTRL_PER]);
        if (wr_ctrl_i) ctrl_d = ctrl_wr;
        start_d = wr_ctrl_i & ctrl_wr[CTRL_EN] & ~ctrl_q[CTRL_EN];
        load_d  = wr_load_i ? CNT_W'(load_m) : load_q;
        count_d = start_q ? load_q :
                  expire  ? (ctrl_q[CTRL_PER] ? load_q : count_q) :
                  run     ? count_q - CNT_W'(1) : count_q;
        exp_d   = expire | (exp_q & ~(wr_status_i & sel_i[0] & wdat_i[0]));
        io_d    = io_q ^ (expire & ctrl_q[CTRL_OE]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            io_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            io_q    <= io_d;
            start_q <= start_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign load_o  = load_q;
    assign count_o = count_q;
    assign exp_o   = exp_q;
    assign io_o    = io_q;

endmodule

// File: rtl/user_proj_timer_array.sv
// user_proj_timer_array: Wishbone-mapped array of N_CH timers with toggle outputs and interrupts.
// Define TIMER_LA_EN to expose channel 0 COUNT / EXP bits on the logic analyzer and allow an LA halt.
module user_proj_timer_array
    import user_proj_timer_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [63:0]     la_data_in,
    input  logic [63:0]     la_oenb,
    output logic [63:0]     la_data_out,
    output logic [N_CH-1:0] io_out,
    output logic [N_CH-1:0] io_oeb,
    output logic [2:0]      irq
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
        $error("user_proj_timer_array: N_CH or CNT_W out of range");
    end

    logic                       ack_q, ack_d, req, wr, halt;
    logic [31:0]                dat_q, dat_d, rdata;
    logic [2:0]                 ch;
    reg_e                       rsel;
    logic [N_CH-1:0][3:0]       ctrl_w;
    logic [N_CH-1:0][CNT_W-1:0] load_w, count_w;
    logic [N_CH-1:0]            exp_w, pend;
    logic                       unused_adr;

    assign ch         = wbs_adr_i[6:4];
    assign rsel       = reg_e'(wbs_adr_i[3:2]);
    assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr         = req & wbs_we_i & ~wbs_adr_i[7];
    assign unused_adr = ^wbs_adr_i[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_ch;
        assign wr_ch = wr & (ch == 3'(i));
        user_proj_timer_ch #(.CNT_W(CNT_W)) u_ch (
            .clk_i      (wb_clk_i),
            .rst_ni     (wb_rst_ni),
            .halt_i     (halt),
            .wr_ctrl_i  (wr_ch & (rsel == REG_CTRL)),
            .wr_load_i  (wr_ch & (rsel == REG_LOAD)),
            .wr_status_i(wr_ch & (rsel == REG_STATUS)),
            .wdat_i     (wbs_dat_i),
            .sel_i      (wbs_sel_i),
            .ctrl_o     (ctrl_w[i]),
            .load_o     (load_w[i]),
            .count_o    (count_w[i]),
            .exp_o      (exp_w[i]),
            .io_o       (io_out[i])
        );
        assign pend[i]   = exp_w[i] & ctrl_w[i][CTRL_IE];
        assign io_oeb[i] = ~ctrl_w[i][CTRL_OE];
    end

    // channels at or beyond N_CH never match the loop and so read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++)
            if (32'(ch) == i)
                rdata = rsel == REG_CTRL  ? 32'(ctrl_w[i])  :
                        rsel == REG_LOAD  ? 32'(load_w[i])  :
                        rsel == REG_COUNT ? 32'(count_w[i]) : 32'(exp_w[i]);
        if (wbs_adr_i[7]) rdata = wbs_adr_i[6:2] == ADR_IRQ_PEND[6:2] ? 32'(pend) : '0;
        ack_d = req;
        dat_d = req & ~wbs_we_i ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {1'b0, pend[0], |pend};

`ifdef TIMER_LA_EN
    logic unused_la;
    assign halt      = ~la_oenb[63] & la_data_in[63];
    assign unused_la = ^{la_data_in[62:0], la_oenb[62:0]};
    always_comb begin
        la_data_out               = '0;
        la_data_out[CNT_W-1:0]    = count_w[0];
        la_data_out[32 +: N_CH]   = exp_w;
    end
`else
    logic unused_la;
    assign halt        = 1'b0;
    assign la_data_out = '0;
    assign unused_la   = ^{la_data_in, la_oenb};
`endif

endmodule

// File: tb/tb_user_proj_timer_array.sv
// tb_user_proj_timer_array: scoreboarded Wishbone bench for the timer array (also covers the TIMER_LA_EN build).
module tb_user_proj_timer_array;

    localparam int          N_CH  = 4;
    localparam int          CNT_W = 16;
    localparam logic [31:0] B     = 32'h3000_0000;
`ifdef TIMER_LA_EN
    localparam bit LA_EN = 1'b1;
`else
    localparam bit LA_EN = 1'b0;
`endif

    logic            clk, rst_n, cyc, stb, we, ack;
    logic [3:0]      sel;
    logic [31:0]     adr, dat_w, dat_r;
    logic [63:0]     la_in, la_oenb, la_out;
    logic [N_CH-1:0] io_out, io_oeb;
    logic [2:0]      irq;

    int          n_chk, n_err, n_ack;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    user_proj_timer_array #(.N_CH(N_CH), .CNT_W(CNT_W), .BASE_ADR(B)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .la_data_in (la_in),
        .la_oenb    (la_oenb),
        .la_data_out(la_out),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // read acks pop the scoreboard; every ack is counted
    always @(negedge clk) begin
        if (ack) begin
            n_ack++;
            if (!we) begin
                if (exp_q.size() == 0) check("unexpected_rd_ack", dat_r, 32'hDEAD_BEEF);
                else check(tag_q.pop_front(), dat_r, exp_q.pop_front());
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string tag);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = ack;
        end
        check({tag, "_ack"}, 32'(got), 1);
        if (!got && !w && exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(tag_q.pop_back());
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_xfer(1'b1, a, d, s, "wr");
    endtask

    task automatic wb_rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        wb_xfer(1'b0, a, 32'h0, 4'hF, tag);
    endtask

    task automatic wb_noack(input logic [31:0] a, input string tag);
        int a0;
        a0 = n_ack;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = 32'h5A; sel = 4'hF;
        repeat (6) @(negedge clk);
        check(tag, 32'(n_ack - a0), 0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        int a0, ec;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; la_in = '0; la_oenb = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_dat", dat_r, 0);
        check("rst_io_out", 32'(io_out), 0);
        check("rst_io_oeb", 32'(io_oeb), 32'hF);
        check("rst_irq", 32'(irq), 0);
        check("rst_la_lo", la_out[31:0], 0);
        check("rst_la_hi", la_out[63:32], 0);
        rst_n = 1'b1;

        // periodic LOAD=5: COUNT 5..0 then reload, EXP 6 cycles after the load
        wb_wr(B + 'h04, 5, 4'hF);
        wb_wr(B + 'h00, 3, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("per_count", 32'(dut.count_w[0]), 32'(5 - k));
            check("per_exp_low", 32'(dut.exp_w[0]), 0);
        end
        @(negedge clk);
        check("per_exp_set", 32'(dut.exp_w[0]), 1);
        check("per_reload", 32'(dut.count_w[0]), 5);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            check("per_count2", 32'(dut.count_w[0]), 32'(5 - k));
        end
        @(negedge clk);
        check("per_reload2", 32'(dut.count_w[0]), 5);

        // one-shot with IE and OUT_EN on channel 0
        wb_wr(B + 'h00, 0, 4'hF);
        wb_wr(B + 'h0C, 1, 4'hF);
        wb_wr(B + 'h04, 3, 4'hF);
        wb_wr(B + 'h00, 'hD, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("os_io_before", 32'(io_out[0]), 0);
            check("os_irq_before", 32'(irq), 0);
        end
        @(negedge clk);
        check("os_io_toggle", 32'(io_out[0]), 1);
        check("os_irq_set", 32'(irq), 3);
        repeat (10) @(negedge clk);
        check("os_single_toggle", 32'(io_out[0]), 1);
        check("os_irq_hold", 32'(irq), 3);
        wb_rd(B + 'h00, 'hC, "os_ctrl_en_clear");
        wb_rd(B + 'h80, 1, "irq_pend");
        wb_rd(B + 'h0C, 1, "os_status");
        wb_wr(B + 'h0C, 1, 4'hF);
        @(negedge clk);
        check("os_irq_clear", 32'(irq), 0);
        wb_rd(B + 'h80, 0, "irq_pend_clear");
        check("os_io_oeb", 32'(io_oeb), 32'hE);

        // LOAD=0 periodic expires every cycle; W1C on an expiry edge loses
        wb_wr(B + 'h24, 0, 4'hF);
        wb_wr(B + 'h20, 'hB, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("p0_io_toggle", 32'(io_out[2]), 32'(k % 2));
        end
        wb_wr(B + 'h2C, 1, 4'hF);
        wb_rd(B + 'h2C, 1, "w1c_race_exp_kept");
        wb_wr(B + 'h20, 0, 4'hF);
        wb_wr(B + 'h2C, 1, 4'hF);
        wb_rd(B + 'h2C, 0, "w1c_idle_clears");

        // byte lanes and back-to-back acks
        wb_wr(B + 'h14, 'h1234, 4'b0001);
        wb_wr(B + 'h14, 'hAB00, 4'b0010);
        wb_rd(B + 'h14, 'hAB34, "load_lanes");
        a0 = n_ack;
        repeat (3) begin
            exp_q.push_back('hAB34);
            tag_q.push_back("b2b_data");
        end
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 'h14; sel = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("b2b_ack_count", 32'(n_ack - a0), 3);
        check("b2b_sb_empty", 32'(exp_q.size()), 0);

        // unmapped channels, offsets and out-of-window addresses
        a0 = n_ack;
        wb_rd(B + 'h70, 0, "ch7_read");
        check("ch7_one_ack", 32'(n_ack - a0), 1);
        wb_wr(B + 'h74, 'hFF, 4'hF);
        wb_rd(B + 'h74, 0, "ch7_load_ignored");
        wb_rd(B + 'h84, 0, "unmapped_read");
        wb_noack(B + 'h100, "oow_0x100_noack");
        wb_noack(32'h2000_0000, "oow_far_noack");

        // reset pulsed in the middle of a LOAD write
        a0 = n_ack;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B + 'h34; dat_w = 'hAB; sel = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack), 0);
        check("rst_mid_oeb", 32'(io_oeb), 32'hF);
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_noack", 32'(n_ack - a0), 0);
        wb_rd(B + 'h34, 0, "rst_load_cleared");
        wb_rd(B + 'h00, 0, "rst_ctrl_cleared");
        check("rst_io_oeb2", 32'(io_oeb), 32'hF);
        check("rst_io_out2", 32'(io_out), 0);

        // logic-analyzer halt (counting continues when the LA feature is absent)
        wb_wr(B + 'h04, 200, 4'hF);
        wb_wr(B + 'h00, 1, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        la_oenb[63] = 1'b0;
        la_in[63]   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ec = LA_EN ? 196 : 196 - k;
            check("halt_count", 32'(dut.count_w[0]), 32'(ec));
            check("la_lo", la_out[31:0], LA_EN ? 32'(ec) : 32'h0);
            check("la_hi", la_out[63:32], 0);
        end
        @(posedge clk); #1;
        la_oenb[63] = 1'b1;
        la_in[63]   = 1'b0;
        repeat (2) @(negedge clk);
        check("halt_resume", 32'(dut.count_w[0]), LA_EN ? 32'd195 : 32'd185);

        check("sb_final_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
